flags_bank_reg: RTL and testbench
=================================

Name: flags_bank_reg

Overview:
- Parametrised successor to the pipeline's two-group condition-flags register.
- Holds NUM_BANKS independent flag words (execution contexts/modes), each split into NUM_GROUPS write groups (default NZ | CV). Each bank also has a shadow copy for save/restore.
- Tracks outstanding in-flight flag writes per bank/group, so the decode stage can stall flag consumers.
- Sits between execute (writer), writeback (retire) and decode (reader/stall).

Parameters:
- NUM_BANKS, 2, number of flag contexts (>=1).
- NUM_GROUPS, 2, independently writable flag groups (group NUM_GROUPS-1 is the MSBs).
- GROUP_W, 2, bits per group; FLAG_W = NUM_GROUPS*GROUP_W (default 4 = NZCV).
- MAX_INFLIGHT, 3, maximum outstanding writes per bank/group; counter width CW = clog2(MAX_INFLIGHT+1).
- BYPASS, 1, 1 = same-cycle write visible on read port and in stall; 0 = registered only.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_bank  in  clog2(NUM_BANKS)  bank written/retired.
- wr_group_en  in  NUM_GROUPS  per-group write enable; also retires one pending write per enabled group.
- wr_flags  in  FLAG_W  new flag values.
- pend_en  in  1  reserve in-flight writes.
- pend_bank  in  clog2(NUM_BANKS)  bank reserved.
- pend_groups  in  NUM_GROUPS  groups reserved.
- save_en  in  1  copy flags[save_bank] into shadow[save_bank].
- restore_en  in  1  copy shadow[save_bank] into flags[save_bank].
- save_bank  in  clog2(NUM_BANKS)  bank for save/restore.
- rd_bank  in  clog2(NUM_BANKS)  bank read.
- rd_need  in  NUM_GROUPS  groups the consumer depends on.
- rd_flags  out  FLAG_W  flags of rd_bank.
- rd_stall  out  1  some needed group still has writes outstanding.
- pend_full  out  1  a reserved group of pend_bank is at MAX_INFLIGHT.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (async, rst_n=0): all flags, shadows and counters are 0, err=0. Outputs follow immediately: rd_flags=0, rd_stall=0, pend_full=0.
- Write: every enabled group g of wr_bank takes wr_flags[g*GROUP_W +: GROUP_W] on the clock edge. Groups are independent; several may be written in one cycle (no priority between groups). Disabled groups hold.
- Next-state merge order per bank:
  1. restore (if restore_en and save_bank matches) replaces all groups;
  2. the write then overwrites its enabled groups. A write wins over a restore.
- save_en captures the merged next-state value, so it includes a same-cycle write. save_en and restore_en together on the same bank: restore is applied and save is ignored; err is set.
- Read: rd_flags is combinational.
  - BYPASS=1: shows the merged next-state of rd_bank (restore/write this cycle visible).
  - BYPASS=0: shows the registered value only.
- Counters: cnt[b][g] is incremented by pend_en for each set bit of pend_groups, and decremented by each enabled write group.
  - Increment and decrement on the same counter in one cycle: no change.
  - Increment at MAX_INFLIGHT: saturates; err is set.
  - Decrement at 0: stays 0; err is set.
- pend_full = OR over set bits of pend_groups of (cnt[pend_bank][g]==MAX_INFLIGHT). This is combinational, so the issuer holds pend_en while it is high.
- rd_stall = OR over set bits of rd_need of (effective count != 0).
  - BYPASS=1: effective count = cnt minus the same-cycle retire for rd_bank, so a retiring last write releases the stall in that same cycle.
  - BYPASS=0: effective count = registered cnt.
- err is sticky until reset.
- Reset asserted mid-operation clears everything; outstanding reservations are lost by design.

Decomposition:
- Shared package flags_pkg holds the FLAG_W/GROUP_W defaults, group index constants (GRP_NZ=1, GRP_CV=0) and bank_idx_t.
- One sub-module, flags_pend_cnt: a single saturating up/down counter with inc, dec, is_zero, is_max and err. It is instantiated NUM_BANKS*NUM_GROUPS times.

Test Plan:
- Reset, then write bank1 groups=2'b11, flags=4'hA → rd_bank=1 gives rd_flags=4'hA (same cycle if BYPASS=1); bank0 stays 4'h0.
- flags[0]=4'hF; write groups=2'b01, flags=4'h0 → 4'hC; then groups=2'b10, flags=4'h4 → 4'h4.
- Save bank0=4'h5; write 4'h9; restore together with write groups=2'b10, flags=4'hC → flags[0]=4'hD.
- pend_en bank0 groups=2'b10 twice; rd_need=2'b10 → rd_stall=1. Retire once → still 1. Second retire → rd_stall=0 in that cycle (BYPASS=1). rd_need=2'b01 never stalls.
- Reserve CV 3 times → pend_full=1; a 4th reservation → err=1, count remains 3. Retire at count 0 → err stays 1.
- Assert rst_n=0 mid-sequence with counts nonzero → all outputs 0 asynchronously, before the next edge.

Source files
------------

// File: rtl/flags_pkg.sv
// rtl/flags_pkg.sv - shared widths, group indices and bank index type for the flags bank
package flags_pkg;
   localparam int GROUP_W_DEF    = 2;
   localparam int NUM_GROUPS_DEF = 2;
   localparam int FLAG_W_DEF     = GROUP_W_DEF * NUM_GROUPS_DEF;
   localparam int NUM_BANKS_DEF  = 2;

   localparam int GRP_NZ = 1;
   localparam int GRP_CV = 0;

   // Index width that stays legal for a single-entry selector.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int BANK_W_DEF = idx_w(NUM_BANKS_DEF);
   typedef logic [BANK_W_DEF-1:0] bank_idx_t;
endpackage

// File: rtl/flags_pend_cnt.sv
// rtl/flags_pend_cnt.sv - saturating up/down count of in-flight writes for one bank/group
module flags_pend_cnt
   import flags_pkg::*;
#(
   parameter int MAX_INFLIGHT = 3,
   parameter int CW           = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc,
   input  logic          dec,
   output logic [CW-1:0] cnt,
   output logic          is_zero,
   output logic          is_max,
   output logic          err
);
   assign is_zero = (cnt == '0);
   assign is_max  = (cnt == CW'(MAX_INFLIGHT));
   // A simultaneous reserve and retire cancel out, so neither can overflow.
   assign err     = (inc && !dec && is_max) || (dec && !inc && is_zero);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (inc && !dec && !is_max) begin
         cnt <= cnt + 1'b1;
      end else if (dec && !inc && !is_zero) begin
         cnt <= cnt - 1'b1;
      end
   end
endmodule

// File: rtl/flags_bank_reg.sv
// rtl/flags_bank_reg.sv - banked condition flags with shadow save/restore and in-flight write tracking
module flags_bank_reg
   import flags_pkg::*;
#(
   parameter  int NUM_BANKS    = NUM_BANKS_DEF,
   parameter  int NUM_GROUPS   = NUM_GROUPS_DEF,
   parameter  int GROUP_W      = GROUP_W_DEF,
   parameter  int MAX_INFLIGHT = 3,
   parameter  int BYPASS       = 1,
   localparam int FLAG_W       = NUM_GROUPS * GROUP_W,
   localparam int BW           = idx_w(NUM_BANKS),
   localparam int CW           = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [BW-1:0]         wr_bank,
   input  logic [NUM_GROUPS-1:0] wr_group_en,
   input  logic [FLAG_W-1:0]     wr_flags,
   input  logic                  pend_en,
   input  logic [BW-1:0]         pend_bank,
   input  logic [NUM_GROUPS-1:0] pend_groups,
   input  logic                  save_en,
   input  logic                  restore_en,
   input  logic [BW-1:0]         save_bank,
   input  logic [BW-1:0]         rd_bank,
   input  logic [NUM_GROUPS-1:0] rd_need,
   output logic [FLAG_W-1:0]     rd_flags,
   output logic                  rd_stall,
   output logic                  pend_full,
   output logic                  err
);
   logic [FLAG_W-1:0]     flags_q   [NUM_BANKS];
   logic [FLAG_W-1:0]     shadow_q  [NUM_BANKS];
   logic [FLAG_W-1:0]     flags_nxt [NUM_BANKS];
   logic [CW-1:0]         cnt       [NUM_BANKS][NUM_GROUPS];
   logic [NUM_GROUPS-1:0] inc       [NUM_BANKS];
   logic [NUM_GROUPS-1:0] dec       [NUM_BANKS];
   logic [NUM_GROUPS-1:0] is_zero   [NUM_BANKS];
   logic [NUM_GROUPS-1:0] is_max    [NUM_BANKS];
   logic [NUM_BANKS*NUM_GROUPS-1:0] cnt_err;

   // Restore lays down the whole word first; the write then overrides its groups.
   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         flags_nxt[b] = flags_q[b];
         if (restore_en && save_bank == BW'(b)) begin
            flags_nxt[b] = shadow_q[b];
         end
         for (int g = 0; g < NUM_GROUPS; g++) begin
            if (wr_bank == BW'(b) && wr_group_en[g]) begin
               flags_nxt[b][g*GROUP_W +: GROUP_W] = wr_flags[g*GROUP_W +: GROUP_W];
            end
         end
      end
   end

   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         for (int g = 0; g < NUM_GROUPS; g++) begin
            inc[b][g] = pend_en && pend_bank == BW'(b) && pend_groups[g];
            dec[b][g] = wr_bank == BW'(b) && wr_group_en[g];
         end
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
         flags_pend_cnt #(
            .MAX_INFLIGHT (MAX_INFLIGHT),
            .CW           (CW)
         ) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc     (inc[b][g]),
            .dec     (dec[b][g]),
            .cnt     (cnt[b][g]),
            .is_zero (is_zero[b][g]),
            .is_max  (is_max[b][g]),
            .err     (cnt_err[b*NUM_GROUPS+g])
         );
      end
   end

   // With bypass, a retire this cycle already counts as done for the stall.
   always_comb begin
      rd_flags  = '0;
      rd_stall  = 1'b0;
      pend_full = 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (rd_bank == BW'(b)) begin
            rd_flags = (BYPASS != 0) ? flags_nxt[b] : flags_q[b];
            for (int g = 0; g < NUM_GROUPS; g++) begin
               if (rd_need[g]) begin
                  rd_stall = rd_stall | ((BYPASS != 0) ? (cnt[b][g] > CW'(dec[b][g]))
                                                       : !is_zero[b][g]);
               end
            end
         end
         if (pend_bank == BW'(b)) begin
            for (int g = 0; g < NUM_GROUPS; g++) begin
               if (pend_groups[g] && is_max[b][g]) begin
                  pend_full = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            flags_q[b]  <= '0;
            shadow_q[b] <= '0;
         end
         err <= 1'b0;
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            flags_q[b] <= flags_nxt[b];
            if (save_en && !restore_en && save_bank == BW'(b)) begin
               shadow_q[b] <= flags_nxt[b];
            end
         end
         err <= err | (save_en && restore_en) | (|cnt_err);
      end
   end
endmodule

// File: tb/tb_flags_bank_reg.sv
// tb/tb_flags_bank_reg.sv - scoreboard bench for flags_bank_reg
module tb_flags_bank_reg;
   import flags_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   bank_idx_t  wr_bank, pend_bank, save_bank, rd_bank;
   logic [1:0] wr_group_en, pend_groups, rd_need;
   logic [3:0] wr_flags;
   logic       pend_en, save_en, restore_en;
   logic [3:0] rd_flags;
   logic       rd_stall, pend_full, err;

   flags_bank_reg #(
      .NUM_BANKS    (2),
      .NUM_GROUPS   (2),
      .GROUP_W      (2),
      .MAX_INFLIGHT (3),
      .BYPASS       (1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_bank     (wr_bank),
      .wr_group_en (wr_group_en),
      .wr_flags    (wr_flags),
      .pend_en     (pend_en),
      .pend_bank   (pend_bank),
      .pend_groups (pend_groups),
      .save_en     (save_en),
      .restore_en  (restore_en),
      .save_bank   (save_bank),
      .rd_bank     (rd_bank),
      .rd_need     (rd_need),
      .rd_flags    (rd_flags),
      .rd_stall    (rd_stall),
      .pend_full   (pend_full),
      .err         (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      int         kind;
      logic [3:0] exp;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check_val(input string tag, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic [3:0] e_flags, input logic e_stall,
                             input logic e_full, input logic e_err);
      sbq.push_back('{{tag, ".rd_flags"},  0, e_flags});
      sbq.push_back('{{tag, ".rd_stall"},  1, {3'b0, e_stall}});
      sbq.push_back('{{tag, ".pend_full"}, 2, {3'b0, e_full}});
      sbq.push_back('{{tag, ".err"},       3, {3'b0, e_err}});
   endtask

   task automatic drain();
      exp_t       e;
      logic [3:0] act;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         case (e.kind)
            0:       act = rd_flags;
            1:       act = {3'b0, rd_stall};
            2:       act = {3'b0, pend_full};
            default: act = {3'b0, err};
         endcase
         check_val(e.tag, act, e.exp);
      end
   endtask

   task automatic step(input string tag, input logic [3:0] e_flags, input logic e_stall,
                       input logic e_full, input logic e_err);
      expect_out(tag, e_flags, e_stall, e_full, e_err);
      #1;
      drain();
   endtask

   task automatic idle();
      wr_bank = '0; wr_group_en = '0; wr_flags = '0;
      pend_en = 1'b0; pend_bank = '0; pend_groups = '0;
      save_en = 1'b0; restore_en = 1'b0; save_bank = '0;
      rd_bank = '0; rd_need = '0;
   endtask

   task automatic reset_pulse(input string tag);
      @(negedge clk); idle(); rst_n = 1'b0;
      step(tag, 4'h0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
   endtask

   initial begin
      idle();
      @(negedge clk);
      step("reset", 4'h0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;

      // flag writes, group merge, save/restore
      @(negedge clk); idle(); wr_bank = 1; wr_group_en = 2'b11; wr_flags = 4'hA; rd_bank = 1;
      step("wr_b1", 4'hA, 1'b0, 1'b0, 1'b0);
      @(negedge clk); idle(); rd_bank = 1;
      step("hold_b1", 4'hA, 1'b0, 1'b0, 1'b1);
      @(negedge clk); idle();
      step("b0_clear", 4'h0, 1'b0, 1'b0, 1'b1);
      @(negedge clk); idle(); wr_group_en = 2'b11; wr_flags = 4'hF;
      step("wr_f", 4'hF, 1'b0, 1'b0, 1'b1);
      @(negedge clk); idle(); wr_group_en = 2'b01; wr_flags = 4'h0;
      step("wr_cv", 4'hC, 1'b0, 1'b0, 1'b1);
      @(negedge clk); idle(); wr_group_en = 2'b10; wr_flags = 4'h4;
      step("wr_nz", 4'h4, 1'b0, 1'b0, 1'b1);
      @(negedge clk); idle(); wr_group_en = 2'b11; wr_flags = 4'h5; save_en = 1'b1;
      step("wr_save", 4'h5, 1'b0, 1'b0, 1'b1);
      @(negedge clk); idle(); wr_group_en = 2'b11; wr_flags = 4'h9;
      step("wr_9", 4'h9, 1'b0, 1'b0, 1'b1);
      @(negedge clk); idle(); restore_en = 1'b1; wr_group_en = 2'b10; wr_flags = 4'hC;
      step("restore_wr", 4'hD, 1'b0, 1'b0, 1'b1);
      @(negedge clk); idle();
      step("restore_hold", 4'hD, 1'b0, 1'b0, 1'b1);
      @(negedge clk); idle(); rd_bank = 1;
      step("b1_kept", 4'hA, 1'b0, 1'b0, 1'b1);

      // in-flight tracking
      reset_pulse("reset2");
      @(negedge clk); idle(); pend_en = 1'b1; pend_groups = 2'b10; rd_need = 2'b10;
      step("nz_res1", 4'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk); idle(); pend_en = 1'b1; pend_groups = 2'b10; rd_need = 2'b10;
      step("nz_res2", 4'h0, 1'b1, 1'b0, 1'b0);
      @(negedge clk); idle(); rd_need = 2'b01;
      step("cv_free", 4'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk); idle(); rd_need = 2'b10;
      step("nz_stall", 4'h0, 1'b1, 1'b0, 1'b0);
      @(negedge clk); idle(); wr_group_en = 2'b10; rd_need = 2'b10;
      step("nz_ret1", 4'h0, 1'b1, 1'b0, 1'b0);
      @(negedge clk); idle(); wr_group_en = 2'b10; rd_need = 2'b10;
      step("nz_ret2", 4'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk); idle(); rd_need = 2'b10;
      step("nz_idle", 4'h0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); idle(); pend_en = 1'b1; pend_groups = 2'b01; rd_need = 2'b01;
         step($sformatf("cv_res%0d", i + 1), 4'h0, (i > 0), (i == 3), 1'b0);
      end
      @(negedge clk); idle(); pend_groups = 2'b01; rd_need = 2'b01;
      step("cv_sat", 4'h0, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); idle(); wr_group_en = 2'b01; pend_groups = 2'b01; rd_need = 2'b01;
         step($sformatf("cv_ret%0d", i + 1), 4'h0, (i < 2), (i == 0), 1'b1);
      end
      @(negedge clk); idle(); wr_group_en = 2'b01; rd_need = 2'b01;
      step("cv_under", 4'h0, 1'b0, 1'b0, 1'b1);
      @(negedge clk); idle(); rd_need = 2'b01;
      step("cv_after", 4'h0, 1'b0, 1'b0, 1'b1);

      // save and restore together
      reset_pulse("reset3");
      @(negedge clk); idle(); pend_en = 1'b1; pend_bank = 1; pend_groups = 2'b11; rd_bank = 1;
      step("c_res", 4'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk); idle(); wr_bank = 1; wr_group_en = 2'b11; wr_flags = 4'h6; rd_bank = 1;
      step("c_wr", 4'h6, 1'b0, 1'b0, 1'b0);
      @(negedge clk); idle(); save_en = 1'b1; restore_en = 1'b1; save_bank = 1; rd_bank = 1;
      step("sr_both", 4'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk); idle(); rd_bank = 1;
      step("sr_err", 4'h0, 1'b0, 1'b0, 1'b1);

      // asynchronous reset with work outstanding
      reset_pulse("reset4");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); idle(); pend_en = 1'b1; pend_bank = 1; pend_groups = 2'b11;
         rd_bank = 1; rd_need = 2'b11;
         step($sformatf("d_res%0d", i + 1), 4'h0, (i > 0), 1'b0, 1'b0);
      end
      @(negedge clk); idle(); wr_bank = 1; wr_group_en = 2'b01; wr_flags = 4'h3;
      pend_bank = 1; pend_groups = 2'b11; rd_bank = 1; rd_need = 2'b11;
      step("d_wr", 4'h3, 1'b1, 1'b1, 1'b0);
      @(negedge clk); idle(); pend_bank = 1; pend_groups = 2'b11; rd_bank = 1; rd_need = 2'b11;
      step("d_busy", 4'h3, 1'b1, 1'b1, 1'b0);
      #1 rst_n = 1'b0;
      expect_out("async_rst", 4'h0, 1'b0, 1'b0, 1'b0);
      #1 drain();
      @(negedge clk); rst_n = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
